// File: rtl/hazard_pkg.sv
// Shared types and helpers for the LEGv8 hazard controller.
package hazard_pkg;

  typedef enum logic {RUN, MUL_WAIT} hz_state_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_t;

  localparam logic [4:0] XZR = 5'd31;

  function automatic fwd_sel_t fwd_pick(
    input logic [4:0] src,
    input logic [4:0] ex_rd,
    input logic       ex_wr,
    input logic [4:0] mem_rd,
    input logic       mem_wr
  );
    fwd_sel_t sel;
    sel = FWD_REG;
    if (src == XZR)
      sel = FWD_REG;
    else if (ex_wr && ex_rd == src)
      sel = FWD_EX;
    else if (mem_wr && mem_rd == src)
      sel = FWD_MEM;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_control_mul_stall_timer.sv
// Down-counter that times the multiply freeze.
module mul_stall_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_control.sv
// Stall, flush and forwarding control for the 5-stage LEGv8 pipeline.
module hazard_control
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_Aa,
  input  logic [4:0]       id_Ab,
  input  logic             id_use_a,
  input  logic             id_use_b,
  input  logic [4:0]       ex_rd,
  input  logic             ex_wr_en,
  input  logic             ex_is_load,
  input  logic             ex_mul_start,
  input  logic             ex_br_taken,
  input  logic [4:0]       mem_rd,
  input  logic             mem_wr_en,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int TW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
  // Start cycle freezes too, so MUL_WAIT lasts MUL_LAT-2 cycles.
  localparam logic [TW-1:0] WAIT_LEN =
    TW'((MUL_LAT > 2) ? MUL_LAT - 3 : 0);

  hz_state_t state, next;
  logic      tmr_load;
  logic      tmr_zero;
  logic      br_flush;
  logic      load_use;

  mul_stall_timer #(.W(TW)) u_tmr (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (WAIT_LEN),
    .zero     (tmr_zero)
  );

  assign load_use = ex_is_load && ex_wr_en && (ex_rd != XZR) &&
    ((id_use_a && id_Aa == ex_rd) ||
     (id_use_b && id_Ab == ex_rd));

  always_comb begin
    next         = state;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    tmr_load     = 1'b0;
    br_flush     = 1'b0;
    fwd_a_sel    = fwd_pick(id_Aa, ex_rd, ex_wr_en,
                            mem_rd, mem_wr_en);
    fwd_b_sel    = fwd_pick(id_Ab, ex_rd, ex_wr_en,
                            mem_rd, mem_wr_en);
    if (!reset_n) begin
      next         = RUN;
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
      fwd_a_sel    = FWD_REG;
      fwd_b_sel    = FWD_REG;
    end else begin
      unique case (state)
        RUN: begin
          if (ex_br_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            br_flush    = 1'b1;
          end else if (ex_mul_start && MUL_LAT > 1) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_bubble = 1'b1;
            if (MUL_LAT > 2) begin
              tmr_load = 1'b1;
              next     = MUL_WAIT;
            end
          end else if (load_use) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        MUL_WAIT: begin
          pc_en        = 1'b0;
          ifid_en      = 1'b0;
          idex_en      = 1'b0;
          exmem_bubble = 1'b1;
          if (tmr_zero)
            next = RUN;
        end
        default: next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= next;
      if (!pc_en && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (br_flush && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_control.sv
// Directed self-checking bench for hazard_control.
module tb_hazard_control;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] id_Aa, id_Ab, ex_rd, mem_rd;
  logic       id_use_a, id_use_b;
  logic       ex_wr_en, ex_is_load, ex_mul_start;
  logic       ex_br_taken, mem_wr_en;
  logic       pc_en, ifid_en, ifid_flush, idex_en;
  logic       idex_bubble, exmem_bubble;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [3:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  hazard_control #(.MUL_LAT(4), .CNT_W(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .id_Aa        (id_Aa),
    .id_Ab        (id_Ab),
    .id_use_a     (id_use_a),
    .id_use_b     (id_use_b),
    .ex_rd        (ex_rd),
    .ex_wr_en     (ex_wr_en),
    .ex_is_load   (ex_is_load),
    .ex_mul_start (ex_mul_start),
    .ex_br_taken  (ex_br_taken),
    .mem_rd       (mem_rd),
    .mem_wr_en    (mem_wr_en),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .ifid_flush   (ifid_flush),
    .idex_en      (idex_en),
    .idex_bubble  (idex_bubble),
    .exmem_bubble (exmem_bubble),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_Aa = 5'd0; id_Ab = 5'd0;
    id_use_a = 1'b0; id_use_b = 1'b0;
    ex_rd = 5'd0; ex_wr_en = 1'b0;
    ex_is_load = 1'b0; ex_mul_start = 1'b0;
    ex_br_taken = 1'b0;
    mem_rd = 5'd0; mem_wr_en = 1'b0;
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    #1;
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    chk("run_pc_en", pc_en, 1);
    chk("run_exmem_bubble", exmem_bubble, 0);

    // asynchronous reset mid-cycle with a forwarding match live
    ex_rd = 5'd3; ex_wr_en = 1'b1; id_Aa = 5'd3;
    #1;
    chk("pre_rst_fwd_a", fwd_a_sel, 1);
    reset_n = 1'b0;
    #1;
    chk("arst_pc_en", pc_en, 0);
    chk("arst_ifid_en", ifid_en, 0);
    chk("arst_idex_en", idex_en, 0);
    chk("arst_ifid_flush", ifid_flush, 1);
    chk("arst_idex_bubble", idex_bubble, 1);
    chk("arst_exmem_bubble", exmem_bubble, 1);
    chk("arst_fwd_a", fwd_a_sel, 0);
    tick();
    reset_n = 1'b1;
    idle();
    tick();
    chk("post_rst_stall_cnt", stall_cnt, 0);

    // forwarding priority
    ex_rd = 5'd3; ex_wr_en = 1'b1;
    mem_rd = 5'd3; mem_wr_en = 1'b1;
    id_Aa = 5'd3; id_Ab = 5'd7;
    #1;
    chk("fwd_a_ex_wins", fwd_a_sel, 1);
    chk("fwd_b_none", fwd_b_sel, 0);
    ex_wr_en = 1'b0;
    #1;
    chk("fwd_a_mem", fwd_a_sel, 2);
    ex_wr_en = 1'b1; ex_rd = 5'd31;
    mem_rd = 5'd31; id_Aa = 5'd31;
    #1;
    chk("fwd_a_xzr", fwd_a_sel, 0);
    ex_rd = 5'd9; id_Ab = 5'd9;
    #1;
    chk("fwd_b_ex", fwd_b_sel, 1);
    chk("fwd_b_no_stall", pc_en, 1);

    // load-use on operand B
    idle();
    ex_rd = 5'd2; ex_wr_en = 1'b1; ex_is_load = 1'b1;
    id_Ab = 5'd2; id_use_b = 1'b1;
    #1;
    chk("lu_pc_en", pc_en, 0);
    chk("lu_ifid_en", ifid_en, 0);
    chk("lu_idex_bubble", idex_bubble, 1);
    chk("lu_idex_en", idex_en, 1);
    tick();
    chk("lu_stall_cnt", stall_cnt, 1);
    idle();
    id_Ab = 5'd2; id_use_b = 1'b1;
    mem_rd = 5'd2; mem_wr_en = 1'b1;
    #1;
    chk("lu_next_fwd_b", fwd_b_sel, 2);
    chk("lu_next_pc_en", pc_en, 1);
    tick();
    chk("lu_next_stall_cnt", stall_cnt, 1);

    // load-use to XZR never stalls
    idle();
    ex_rd = 5'd31; ex_wr_en = 1'b1; ex_is_load = 1'b1;
    id_Aa = 5'd31; id_use_a = 1'b1;
    #1;
    chk("lu_xzr_pc_en", pc_en, 1);

    // taken branch overrides load-use
    idle();
    ex_rd = 5'd2; ex_wr_en = 1'b1; ex_is_load = 1'b1;
    id_Aa = 5'd2; id_use_a = 1'b1;
    ex_br_taken = 1'b1;
    #1;
    chk("br_ifid_flush", ifid_flush, 1);
    chk("br_idex_bubble", idex_bubble, 1);
    chk("br_pc_en", pc_en, 1);
    tick();
    chk("br_flush_cnt", flush_cnt, 1);
    chk("br_stall_cnt", stall_cnt, 1);

    // multiply: three frozen cycles, branch ignored in cycle 2
    idle();
    ex_mul_start = 1'b1;
    #1;
    chk("mul_c1_pc_en", pc_en, 0);
    chk("mul_c1_exmem", exmem_bubble, 1);
    tick();
    ex_mul_start = 1'b0;
    ex_br_taken = 1'b1;
    #1;
    chk("mul_c2_pc_en", pc_en, 0);
    chk("mul_c2_flush", ifid_flush, 0);
    chk("mul_c2_exmem", exmem_bubble, 1);
    tick();
    ex_br_taken = 1'b0;
    #1;
    chk("mul_c3_pc_en", pc_en, 0);
    chk("mul_c3_ifid_en", ifid_en, 0);
    chk("mul_c3_exmem", exmem_bubble, 1);
    tick();
    chk("mul_c4_pc_en", pc_en, 1);
    chk("mul_c4_exmem", exmem_bubble, 0);
    chk("mul_stall_cnt", stall_cnt, 4);
    chk("mul_flush_cnt", flush_cnt, 1);

    // reset during MUL_WAIT abandons the multiply
    ex_mul_start = 1'b1;
    tick();
    ex_mul_start = 1'b0;
    #1;
    chk("mulrst_wait_pc_en", pc_en, 0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    chk("mulrst_run_pc_en", pc_en, 1);
    chk("mulrst_stall_cnt", stall_cnt, 0);

    // stall counter saturates at 15
    ex_rd = 5'd4; ex_wr_en = 1'b1; ex_is_load = 1'b1;
    id_Aa = 5'd4; id_use_a = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall_cnt", stall_cnt, 15);
    chk("sat_flush_cnt", flush_cnt, 0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
